// File: rtl/rng_arbiter.sv
// rng_arbiter
//   Shares one free-running 16-bit LFSR between NUM_REQ consumers. Each
//   consumer asks for a 3-bit value in 0..limit. Requests are served in
//   round-robin order. Each candidate draw is rejection-sampled against the
//   latched limit. After MAX_TRIES rejected draws the limit itself is returned.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   req         per-requester level request, held until its ack
//   limit       per-requester inclusive upper bound, slice i = [3i+2:3i]
//   ack         one-cycle pulse to the served requester
//   data        random value, qualified by data_valid
//   data_valid  high together with any ack bit
//   busy        high while in DRAW or DONE
module rng_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter int          MAX_TRIES = 4,
    parameter logic [15:0] SEED      = 16'h3CF5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   limit,
    output logic [NUM_REQ-1:0]     ack,
    output logic [2:0]             data,
    output logic                   data_valid,
    output logic                   busy
);

    localparam int                 IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0]      LAST     = IW'(NUM_REQ - 1);
    localparam logic [3:0]         TRY_LAST = 4'(MAX_TRIES - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_shift;
    logic [15:0]   lfsr_next;
    logic [2:0]    cand;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic [2:0]    lim;
    logic [3:0]    tries;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [2:0]    pick_lim;
    int            pick_j;

    // The all-zero state would lock the register, so it is replaced by SEED.
    assign lfsr_shift = {lfsr[14:0], lfsr[1] ^ lfsr[3] ^ lfsr[5] ^ lfsr[6]};
    assign lfsr_next  = (lfsr_shift == 16'h0000) ? SEED : lfsr_shift;
    assign cand       = lfsr[15:13];

    // Round-robin search starting at rr_ptr. The offsets are walked from the
    // far end back toward rr_ptr, so the closest requester is written last
    // and wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_lim   = '0;
        pick_j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_j = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[pick_j]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(pick_j);
                pick_lim   = limit[3*pick_j +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= SEED;
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            lim        <= '0;
            tries      <= '0;
            ack        <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            lfsr       <= lfsr_next;
            ack        <= '0;
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        lim   <= pick_lim;
                        tries <= '0;
                        busy  <= 1'b1;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (!req[grant]) begin
                        // The requester gave up. rr_ptr stays put, so it keeps its turn.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cand <= lim) begin
                        data       <= cand;
                        ack        <= ONE << grant;
                        data_valid <= 1'b1;
                        state      <= DONE;
                    end else if (tries == TRY_LAST) begin
                        data       <= lim;
                        ack        <= ONE << grant;
                        data_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tries <= tries + 4'd1;
                    end
                end
                DONE: begin
                    rr_ptr <= (grant == LAST) ? '0 : grant + IW'(1);
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Owns the game's single 16-bit pseudo-random source and shares it between up to NUM_REQ consumers, e.g. serve direction, serve speed, AI paddle jitter and spin.
- Each consumer requests a 3-bit random value in the range 0..limit.
- The block arbitrates round-robin, draws from the LFSR with rejection sampling (bounded retries), and returns the value with a one-cycle ack.
- Sits between the game-logic FSMs and the random source; it replaces direct taps of LFSR bits.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MAX_TRIES, 4: draws attempted per request before fallback (1..15).
- SEED, 16'h3CF5: LFSR reset and reseed value; must be non-zero.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req  in  NUM_REQ  per-requester level request; held until matching ack.
- limit  in  3*NUM_REQ  per-requester inclusive upper bound; requester i uses bits [3i+2:3i].
- ack  out  NUM_REQ  one-cycle pulse to the served requester.
- data  out  3  random value; valid only while data_valid=1.
- data_valid  out  1  high in the same cycle as any ack bit.
- busy  out  1  high in the DRAW and DONE states.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - lfsr=SEED, state=IDLE, rr_ptr=0, grant=0, tries=0.
  - ack=0, data=0, data_valid=0, busy=0.
- LFSR: free-runs every cycle, independent of the FSM.
  - next = {lfsr[14:0], lfsr[1]^lfsr[3]^lfsr[5]^lfsr[6]}.
  - If next==16'h0000, load SEED instead (lock-up guard).
  - Candidate value cand = lfsr[15:13], taken from the current-cycle register.
- FSM states: IDLE, DRAW, DONE.
- IDLE: if any req bit is high, select the first set bit searching from rr_ptr upward with wrap.
  - Latch grant=index and lim=limit slice, set tries=0, go to DRAW.
  - If no req bit is high, stay in IDLE.
- DRAW: evaluated once per cycle.
  - If req[grant]==0 (withdrawn), go to IDLE with no ack and rr_ptr unchanged.
  - Else if cand<=lim: data<=cand, go to DONE.
  - Else if tries==MAX_TRIES-1: data<=lim (fallback), go to DONE.
  - Else tries<=tries+1 and stay in DRAW; the next cycle uses the next LFSR value.
- DONE: ack[grant]=1 and data_valid=1 for exactly one cycle.
  - rr_ptr<=(grant+1) mod NUM_REQ; go to IDLE.
- Latency: minimum 2 cycles from req sampled in IDLE to ack. Worst case is MAX_TRIES+1 cycles.
  - Back-to-back service costs 3 cycles per grant (IDLE, DRAW, DONE).
- lim==7 always accepts on the first draw. lim==0 accepts only cand==0; otherwise it falls back to 0.
- Requester handshake: must deassert req in the cycle after ack, or keep it high to re-request. A re-request competes behind the other requesters because rr_ptr has advanced.
- Changes to a limit slice after the grant cycle are ignored, since lim is latched.
- Requests arriving while busy are held off; they are evaluated in the next IDLE cycle.
- Reset in the middle of DRAW or DONE: abort immediately. No ack is issued and the LFSR returns to SEED.
- data holds its last value outside DONE; consumers qualify it with data_valid.

Test Plan:
- Reset, then req=4'b0001, limit0=7 at the first cycle (lfsr=0x3CF5) -> ack[0] and data_valid two cycles later; data=3 (lfsr=0x79EA at DRAW).
- Same as above with limit0=2 -> candidates 3,7,7,6 from lfsr 0x79EA,0xF3D4,0xE7A9,0xCF52 are all rejected; fallback data=2, ack at cycle 5.
- req=4'b1111 held, all limits=7 -> acks in order 0,1,2,3,0 at 3-cycle spacing; exactly one ack bit high per pulse; data always <=7.
- req[2] dropped during DRAW with limit=0 -> no ack; FSM returns to IDLE; rr_ptr unchanged, so the next req[2] is served first.
- Force lfsr to 0x8000 (fb=0, next would be 0) -> lfsr loads 0x3CF5 the next cycle and never holds 0.
- Assert rst in DRAW -> the next cycle shows ack=0, data_valid=0, busy=0, lfsr=0x3CF5.
